// File: rtl/i2s_tx_ser.sv
// I2S (Philips) transmit serializer with one-word holding register; optional underrun counter via I2S_TX_UDR_CNT_EN.
// Latency: accepted word goes out on the next channel slot. Backpressure: ready_o low while a word is held.
module i2s_tx_ser #(
  parameter int DATA_WIDTH = 32,
  parameter int PSCR_WIDTH = 16
) (
  input  logic                  aud_clk_i,
  input  logic                  aud_rst_i,
  input  logic                  en_i,
  input  logic                  pol_i,
  input  logic [PSCR_WIDTH-1:0] pscr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  sck_o,
  output logic                  ws_o,
  output logic                  sd_o,
  output logic                  udr_o
`ifdef I2S_TX_UDR_CNT_EN
  ,
  output logic [15:0]           udr_cnt_o
`endif
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  logic [PSCR_WIDTH-1:0] div_cnt;
  logic                  sck_q;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  hold_vld;
  logic [BW-1:0]         bit_cnt;
  logic                  ws_q;
  logic                  sd_q;
  logic                  udr_q;

  logic run;
  logic half_done;
  logic fall;
  logic load;
  logic accept;
  logic udr_set;

  // Everything is gated by run so a dropping enable never completes a pending event.
  assign run       = en_i && !aud_rst_i;
  assign half_done = (div_cnt >= pscr_i);
  assign fall      = run && half_done && sck_q;
  assign load      = fall && (bit_cnt == LAST_BIT);
  assign ready_o   = run && !hold_vld;
  assign accept    = valid_i && ready_o;
  assign udr_set   = load && !hold_vld;

  always_ff @(posedge aud_clk_i) begin
    if (!run) begin
      div_cnt  <= '0;
      sck_q    <= 1'b0;
      ws_q     <= 1'b1;
      sd_q     <= 1'b0;
      shreg    <= '0;
      bit_cnt  <= LAST_BIT;
      hold_vld <= 1'b0;
      udr_q    <= 1'b0;
    end else begin
      if (half_done) begin
        div_cnt <= '0;
        sck_q   <= ~sck_q;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      udr_q <= udr_set;

      // The LSB leaves together with the WS change, so the new MSB follows one SCK later.
      if (fall) begin
        sd_q <= shreg[DATA_WIDTH-1];
        if (load) begin
          ws_q    <= ~ws_q;
          bit_cnt <= '0;
          shreg   <= hold_vld ? hold_q : '0;
        end else begin
          shreg   <= {shreg[DATA_WIDTH-2:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      if (accept) begin
        hold_q   <= data_i;
        hold_vld <= 1'b1;
      end else if (load) begin
        hold_vld <= 1'b0;
      end
    end
  end

  assign sck_o = sck_q ^ pol_i;
  assign ws_o  = ws_q;
  assign sd_o  = sd_q;
  assign udr_o = udr_q;

`ifdef I2S_TX_UDR_CNT_EN
  logic [15:0] udr_cnt_q;

  // Survives enable toggling; only reset clears the count.
  always_ff @(posedge aud_clk_i) begin
    if (aud_rst_i) begin
      udr_cnt_q <= '0;
    end else if (udr_set && (udr_cnt_q != 16'hFFFF)) begin
      udr_cnt_q <= udr_cnt_q + 1'b1;
    end
  end

  assign udr_cnt_o = udr_cnt_q;
`else
  // Counter not built in this configuration.
`endif

endmodule

// File: tb/tb_i2s_tx_ser.sv
// Directed self-checking bench for i2s_tx_ser with DATA_WIDTH=16.
module tb_i2s_tx_ser;

  logic        clk;
  logic        rst;
  logic        en;
  logic        pol;
  logic [15:0] pscr;
  logic [15:0] data;
  logic        valid;
  logic        ready;
  logic        sck;
  logic        ws;
  logic        sd;
  logic        udr;
`ifdef I2S_TX_UDR_CNT_EN
  logic [15:0] udr_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int udr_seen;
  logic glitch;

  i2s_tx_ser #(.DATA_WIDTH(16), .PSCR_WIDTH(16)) dut (
    .aud_clk_i (clk),
    .aud_rst_i (rst),
    .en_i      (en),
    .pol_i     (pol),
    .pscr_i    (pscr),
    .data_i    (data),
    .valid_i   (valid),
    .ready_o   (ready),
    .sck_o     (sck),
    .ws_o      (ws),
    .sd_o      (sd),
    .udr_o     (udr)
`ifdef I2S_TX_UDR_CNT_EN
    ,
    .udr_cnt_o (udr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; valid = 1'b0; data = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Advance until sck_q falls; reports cycles taken and flags any sd/ws change off a fall.
  task automatic wait_fall(output int ncyc);
    logic p_sck, p_sd, p_ws;
    ncyc = 0;
    for (int i = 0; i < 100; i++) begin
      p_sck = sck; p_sd = sd; p_ws = ws;
      tick();
      ncyc++;
      if (udr) udr_seen++;
      if (p_sck == (1'b1 ^ pol) && sck == (1'b0 ^ pol)) return;
      if (sd !== p_sd || ws !== p_ws) glitch = 1'b1;
    end
    n_cmp++; n_err++;
    $display("FAIL fall_timeout: no SCK fall within 100 cycles");
  endtask

  task automatic collect(input int n, output logic [15:0] w, output logic [15:0] wsv);
    int nc;
    w = '0; wsv = '0;
    for (int i = 0; i < n; i++) begin
      wait_fall(nc);
      w   = {w[14:0], sd};
      wsv = {wsv[14:0], ws};
    end
  endtask

  task automatic push_first(input logic [15:0] w);
    en = 1'b1; valid = 1'b1; data = w;
    tick();
    valid = 1'b0;
  endtask

  task automatic test_reset();
    pol = 1'b0; pscr = 16'd0;
    rst = 1'b1; en = 1'b0; valid = 1'b0; data = '0;
    tick();
    n_cmp++;
    if ({sck, ws, sd, ready, udr} !== 5'b01000) begin
      n_err++;
      $display("FAIL reset_idle: got %b exp 01000", {sck, ws, sd, ready, udr});
    end
`ifdef I2S_TX_UDR_CNT_EN
    n_cmp++;
    if (udr_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_cnt: got %0d exp 0", udr_cnt);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_clock();
    int nc;
    pol = 1'b0; pscr = 16'd1;
    do_reset();
    push_first(16'hA5C3);
    n_cmp++;
    if (ready !== 1'b0) begin
      n_err++;
      $display("FAIL clk_ready_after_accept: got %b exp 0", ready);
    end
    wait_fall(nc);
    n_cmp++;
    if (nc + 1 !== 4) begin
      n_err++;
      $display("FAIL clk_first_fall: got %0d exp 4", nc + 1);
    end
    wait_fall(nc);
    n_cmp++;
    if (nc !== 4) begin
      n_err++;
      $display("FAIL clk_period_p1: got %0d exp 4", nc);
    end
    pscr = 16'd0;
    wait_fall(nc);
    n_cmp++;
    if (nc !== 2) begin
      n_err++;
      $display("FAIL clk_period_p0: got %0d exp 2", nc);
    end
  endtask

  task automatic test_frame();
    int nc;
    logic [15:0] w, wsv;
    pol = 1'b0; pscr = 16'd0;
    do_reset();
    glitch = 1'b0;
    push_first(16'hA5C3);
    wait_fall(nc);
    n_cmp++;
    if ({ws, sd} !== 2'b00) begin
      n_err++;
      $display("FAIL frame_ws_fall: ws,sd got %b exp 00", {ws, sd});
    end
    valid = 1'b1; data = 16'h0F01;
    collect(16, w, wsv);
    valid = 1'b0;
    n_cmp++;
    if (w !== 16'hA5C3) begin
      n_err++;
      $display("FAIL frame_left: got %h exp a5c3", w);
    end
    n_cmp++;
    if (wsv !== 16'h0001) begin
      n_err++;
      $display("FAIL frame_left_ws: got %h exp 0001", wsv);
    end
    collect(16, w, wsv);
    n_cmp++;
    if (w !== 16'h0F01) begin
      n_err++;
      $display("FAIL frame_right: got %h exp 0f01", w);
    end
    n_cmp++;
    if (wsv !== 16'hFFFE) begin
      n_err++;
      $display("FAIL frame_right_ws: got %h exp fffe", wsv);
    end
    n_cmp++;
    if (glitch !== 1'b0) begin
      n_err++;
      $display("FAIL frame_stable: sd/ws changed off a fall, got %b exp 0", glitch);
    end
  endtask

  task automatic test_underrun();
    int nc;
    logic [15:0] w, wsv;
    pol = 1'b0; pscr = 16'd0;
    do_reset();
    push_first(16'h8001);
    wait_fall(nc);
    udr_seen = 0;
    collect(16, w, wsv);
    n_cmp++;
    if (w !== 16'h8001) begin
      n_err++;
      $display("FAIL udr_left: got %h exp 8001", w);
    end
    n_cmp++;
    if (udr !== 1'b1) begin
      n_err++;
      $display("FAIL udr_pulse: got %b exp 1", udr);
    end
    tick();
    n_cmp++;
    if (udr !== 1'b0) begin
      n_err++;
      $display("FAIL udr_pulse_end: got %b exp 0", udr);
    end
`ifdef I2S_TX_UDR_CNT_EN
    n_cmp++;
    if (udr_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL udr_cnt: got %0d exp 1", udr_cnt);
    end
`endif
    collect(15, w, wsv);
    n_cmp++;
    if (w !== 16'h0000) begin
      n_err++;
      $display("FAIL udr_right_zero: got %h exp 0000", w);
    end
    n_cmp++;
    if (wsv !== 16'h7FFF) begin
      n_err++;
      $display("FAIL udr_right_ws: got %h exp 7fff", wsv);
    end
    n_cmp++;
    if (udr_seen !== 1) begin
      n_err++;
      $display("FAIL udr_count_pulses: got %0d exp 1", udr_seen);
    end
  endtask

  task automatic test_polarity();
    int nc;
    logic [15:0] w, wsv;
    pol = 1'b1; pscr = 16'd3;
    do_reset();
    n_cmp++;
    if (sck !== 1'b1) begin
      n_err++;
      $display("FAIL pol_idle_sck: got %b exp 1", sck);
    end
    push_first(16'h3C5A);
    wait_fall(nc);
    n_cmp++;
    if (nc + 1 !== 8) begin
      n_err++;
      $display("FAIL pol_first_fall: got %0d exp 8", nc + 1);
    end
    collect(16, w, wsv);
    n_cmp++;
    if (w !== 16'h3C5A) begin
      n_err++;
      $display("FAIL pol_left: got %h exp 3c5a", w);
    end
    n_cmp++;
    if (wsv !== 16'h0001) begin
      n_err++;
      $display("FAIL pol_left_ws: got %h exp 0001", wsv);
    end
    wait_fall(nc);
    n_cmp++;
    if (nc !== 8) begin
      n_err++;
      $display("FAIL pol_period: got %0d exp 8", nc);
    end
  endtask

  task automatic test_abort();
    int nc;
    logic [15:0] w, wsv;
    pol = 1'b0; pscr = 16'd0;
    do_reset();
    push_first(16'hF800);
    wait_fall(nc);
    valid = 1'b1; data = 16'h0F01;
    wait_fall(nc);
    valid = 1'b0;
    collect(4, w, wsv);
    n_cmp++;
    if ({ws, sd} !== 2'b01) begin
      n_err++;
      $display("FAIL abort_pre: ws,sd got %b exp 01", {ws, sd});
    end
    tick();
    en = 1'b0;
    tick();
    n_cmp++;
    if ({sck, ws, sd, ready, udr} !== 5'b01000) begin
      n_err++;
      $display("FAIL abort_idle: got %b exp 01000", {sck, ws, sd, ready, udr});
    end
    en = 1'b1; valid = 1'b1; data = 16'h1234;
    #1;
    n_cmp++;
    if (ready !== 1'b1) begin
      n_err++;
      $display("FAIL abort_hold_discarded: ready got %b exp 1", ready);
    end
    tick();
    valid = 1'b0;
    wait_fall(nc);
    n_cmp++;
    if ({ws, udr} !== 2'b00) begin
      n_err++;
      $display("FAIL abort_restart_left: ws,udr got %b exp 00", {ws, udr});
    end
    collect(16, w, wsv);
    n_cmp++;
    if (w !== 16'h1234) begin
      n_err++;
      $display("FAIL abort_restart_word: got %h exp 1234", w);
    end
    n_cmp++;
    if (wsv !== 16'h0001) begin
      n_err++;
      $display("FAIL abort_restart_ws: got %h exp 0001", wsv);
    end
  endtask

  task automatic test_reset_priority();
    int nc;
    logic [15:0] w, wsv;
    pol = 1'b0; pscr = 16'd0;
    do_reset();
    rst = 1'b1; en = 1'b1; valid = 1'b1; data = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({sck, ws, sd, ready, udr} !== 5'b01000) begin
        n_err++;
        $display("FAIL rstprio_idle[%0d]: got %b exp 01000", i, {sck, ws, sd, ready, udr});
      end
    end
    rst = 1'b0; valid = 1'b0;
    wait_fall(nc);
    n_cmp++;
    if (udr !== 1'b1) begin
      n_err++;
      $display("FAIL rstprio_no_accept: udr got %b exp 1", udr);
    end
    collect(16, w, wsv);
    n_cmp++;
    if (w !== 16'h0000) begin
      n_err++;
      $display("FAIL rstprio_left_zero: got %h exp 0000", w);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pol = 1'b0; pscr = '0; data = '0; valid = 1'b0;
    udr_seen = 0; glitch = 1'b0;
    test_reset();
    test_clock();
    test_frame();
    test_underrun();
    test_polarity();
    test_abort();
    test_reset_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
